pipe_stage_reg: RTL and testbench

//   Parametrised inter-stage pipeline register for the 5-stage MIPS core (D/E, E/M, M/W slots).

---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one inter-stage pipeline register slot (D/E, E/M or M/W) of the
// 5-stage MIPS core. Holds the valid bit, instruction, PC, NUM_WORDS payload words and
// the control bundle. Supports stall (hold), flush (bubble) and a saturating Tnew
// decrement applied on the way out.
// Optional feature macro: PIPE_REG_STATS_EN adds StallCnt/BubbleCnt saturating counters.
module pipe_stage_reg #(
  parameter int          NUM_WORDS = 2,
  parameter int          CTRL_LEN  = 31,
  parameter int          TNEW_LSB  = 8,
  parameter int          TNEW_W    = 3,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      En,
  input  logic                      Flush,
  input  logic                      ValidIn,
  input  logic [31:0]               InsIn,
  input  logic [31:0]               PCIn,
  input  logic [NUM_WORDS*32-1:0]   DataIn,
  input  logic [CTRL_LEN-1:0]       CtrlIn,
  output logic                      ValidOut,
  output logic [31:0]               InsOut,
  output logic [31:0]               PCOut,
  output logic [NUM_WORDS*32-1:0]   DataOut,
  output logic [CTRL_LEN-1:0]       CtrlOut
`ifdef PIPE_REG_STATS_EN
  ,
  output logic [15:0]               StallCnt,
  output logic [15:0]               BubbleCnt
`endif
);

  localparam int DATA_W = NUM_WORDS * 32;

  // Register bank. The declaration values give the reset contents from time 0,
  // before the first Reset edge arrives.
  logic                r_valid = 1'b0;
  logic [31:0]         r_ins   = 32'h0000_0000;
  logic [31:0]         r_pc    = RESET_PC;
  logic [DATA_W-1:0]   r_data  = {DATA_W{1'b0}};
  logic [CTRL_LEN-1:0] r_ctrl  = {CTRL_LEN{1'b0}};

  logic [TNEW_W-1:0]   w_tnew;
  logic [TNEW_W-1:0]   w_tnew_dec;
  logic [CTRL_LEN-1:0] w_ctrl_out;

  // Pipeline slot update: Reset > Flush > hold (En=0) > load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_ins   <= 32'h0000_0000;
      r_pc    <= RESET_PC;
      r_data  <= {DATA_W{1'b0}};
      r_ctrl  <= {CTRL_LEN{1'b0}};
    end else if (Flush) begin
      // Bubble: no RegWrite/MemWrite, but PC is kept for EPC/delay-slot tracking.
      r_valid <= 1'b0;
      r_ins   <= 32'h0000_0000;
      r_pc    <= PCIn;
      r_data  <= {DATA_W{1'b0}};
      r_ctrl  <= {CTRL_LEN{1'b0}};
    end else if (En) begin
      r_valid <= ValidIn;
      r_ins   <= InsIn;
      r_pc    <= PCIn;
      r_data  <= DataIn;
      r_ctrl  <= CtrlIn;
    end else begin
      r_valid <= r_valid;
      r_ins   <= r_ins;
      r_pc    <= r_pc;
      r_data  <= r_data;
      r_ctrl  <= r_ctrl;
    end
  end

  // Outgoing control: Tnew field decremented, saturating at zero; other bits pass through.
  always_comb begin
    w_tnew     = r_ctrl[TNEW_LSB +: TNEW_W];
    w_tnew_dec = {TNEW_W{1'b0}};
    w_ctrl_out = r_ctrl;
    if (w_tnew == {TNEW_W{1'b0}}) begin
      w_tnew_dec = {TNEW_W{1'b0}};
    end else begin
      w_tnew_dec = w_tnew - TNEW_W'(1);
    end
    w_ctrl_out[TNEW_LSB +: TNEW_W] = w_tnew_dec;
  end

  assign ValidOut = r_valid;
  assign InsOut   = r_ins;
  assign PCOut    = r_pc;
  assign DataOut  = r_data;
  assign CtrlOut  = w_ctrl_out;

`ifdef PIPE_REG_STATS_EN
  logic [15:0] r_stall_cnt  = 16'h0000;
  logic [15:0] r_bubble_cnt = 16'h0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Stall counter: cycles a real (valid) instruction is held in this slot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (!Flush && !En && r_valid) begin
      r_stall_cnt <= sat_inc16(r_stall_cnt);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Bubble counter: cycles a flush inserts a bubble into this slot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bubble_cnt <= 16'h0000;
    end else if (Flush) begin
      r_bubble_cnt <= sat_inc16(r_bubble_cnt);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign StallCnt  = r_stall_cnt;
  assign BubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (NUM_WORDS=3). A reference model predicts the
// slot contents when each cycle's stimulus is driven; the prediction is queued and
// compared after the clock edge.
module tb_pipe_stage_reg;

  localparam int          NW       = 3;
  localparam int          CL       = 31;
  localparam int          DW       = NW * 32;
  localparam logic [31:0] RST_PC   = 32'h0000_3000;

  logic          Clk = 1'b0;
  logic          Reset, En, Flush, ValidIn;
  logic [31:0]   InsIn, PCIn;
  logic [DW-1:0] DataIn;
  logic [CL-1:0] CtrlIn;
  logic          ValidOut;
  logic [31:0]   InsOut, PCOut;
  logic [DW-1:0] DataOut;
  logic [CL-1:0] CtrlOut;
  logic [15:0]   stall_cnt_s, bubble_cnt_s;

  pipe_stage_reg #(
    .NUM_WORDS (NW),
    .CTRL_LEN  (CL),
    .TNEW_LSB  (8),
    .TNEW_W    (3),
    .RESET_PC  (RST_PC)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Flush    (Flush),
    .ValidIn  (ValidIn),
    .InsIn    (InsIn),
    .PCIn     (PCIn),
    .DataIn   (DataIn),
    .CtrlIn   (CtrlIn),
    .ValidOut (ValidOut),
    .InsOut   (InsOut),
    .PCOut    (PCOut),
    .DataOut  (DataOut),
    .CtrlOut  (CtrlOut)
`ifdef PIPE_REG_STATS_EN
    ,
    .StallCnt (stall_cnt_s),
    .BubbleCnt(bubble_cnt_s)
`endif
  );

`ifndef PIPE_REG_STATS_EN
  assign stall_cnt_s  = 16'h0000;
  assign bubble_cnt_s = 16'h0000;
`endif

  always #5 Clk = ~Clk;

  typedef struct {
    logic          valid;
    logic [31:0]   ins;
    logic [31:0]   pc;
    logic [DW-1:0] data;
    logic [CL-1:0] ctrl;
    logic [15:0]   stall;
    logic [15:0]   bubble;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic          m_valid  = 1'b0;
  logic [31:0]   m_ins    = 32'h0;
  logic [31:0]   m_pc     = RST_PC;
  logic [DW-1:0] m_data   = {DW{1'b0}};
  logic [CL-1:0] m_ctrl   = {CL{1'b0}};
  logic [15:0]   m_stall  = 16'h0;
  logic [15:0]   m_bubble = 16'h0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CL-1:0] dec_tnew(input logic [CL-1:0] c);
    logic [2:0] t;
    logic [CL-1:0] r;
    r = c;
    t = c[10:8];
    if (t != 3'd0) t = t - 3'd1;
    r[10:8] = t;
    return r;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check_val({tag, ".valid"}, DW'(ValidOut), DW'(e.valid));
    check_val({tag, ".ins"},   DW'(InsOut),   DW'(e.ins));
    check_val({tag, ".pc"},    DW'(PCOut),    DW'(e.pc));
    check_val({tag, ".data"},  DataOut,       e.data);
    check_val({tag, ".ctrl"},  DW'(CtrlOut),  DW'(e.ctrl));
`ifdef PIPE_REG_STATS_EN
    check_val({tag, ".stall"},  DW'(stall_cnt_s),  DW'(e.stall));
    check_val({tag, ".bubble"}, DW'(bubble_cnt_s), DW'(e.bubble));
`endif
  endtask

  // Drive one cycle, predict, push; after the edge pop and compare.
  task automatic cycle(input string tag, input logic rst, input logic en, input logic fl,
                       input logic vi, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [DW-1:0] data, input logic [CL-1:0] ctrl);
    exp_t e;
    @(negedge Clk);
    Reset = rst; En = en; Flush = fl; ValidIn = vi;
    InsIn = ins; PCIn = pc; DataIn = data; CtrlIn = ctrl;
    if (rst) begin
      m_valid = 1'b0; m_ins = 32'h0; m_pc = RST_PC; m_data = {DW{1'b0}}; m_ctrl = {CL{1'b0}};
      m_stall = 16'h0; m_bubble = 16'h0;
    end else if (fl) begin
      m_valid = 1'b0; m_ins = 32'h0; m_pc = pc; m_data = {DW{1'b0}}; m_ctrl = {CL{1'b0}};
      m_bubble = sat16(m_bubble);
    end else if (!en) begin
      if (m_valid) m_stall = sat16(m_stall);
    end else begin
      m_valid = vi; m_ins = ins; m_pc = pc; m_data = data; m_ctrl = ctrl;
    end
    e.valid = m_valid; e.ins = m_ins; e.pc = m_pc; e.data = m_data;
    e.ctrl = dec_tnew(m_ctrl); e.stall = m_stall; e.bubble = m_bubble;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, DW'(0), DW'(1));
    end else begin
      e = exp_q.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CL-1:0]  c;
    logic [DW-1:0]  d;
    exp_t           e0;
    Reset = 1'b1; En = 1'b0; Flush = 1'b0; ValidIn = 1'b0;
    InsIn = 32'h0; PCIn = 32'h0; DataIn = {DW{1'b0}}; CtrlIn = {CL{1'b0}};

    // time-0 state before any edge
    #1;
    e0.valid = 1'b0; e0.ins = 32'h0; e0.pc = 32'h0000_3000; e0.data = {DW{1'b0}};
    e0.ctrl = {CL{1'b0}}; e0.stall = 16'h0; e0.bubble = 16'h0;
    compare_outputs("t0", e0);

    // 1: reset
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, {DW{1'b0}}, {CL{1'b0}});
    check_val("reset_pc_abs", DW'(PCOut), DW'(32'h0000_3000));

    // 2: load with Tnew=2
    c = 31'h2B3C_4DEF; c[10:8] = 3'd2;
    d = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    cycle("load", 1'b0, 1'b1, 1'b0, 1'b1, 32'h3C01_0001, 32'h0000_3004, d, c);
    check_val("load_tnew_abs", DW'(CtrlOut[10:8]), DW'(3'd1));
    check_val("word0", DW'(DataOut[31:0]),  DW'(32'h0000_000A));
    check_val("word1", DW'(DataOut[63:32]), DW'(32'h0000_000B));
    check_val("word2", DW'(DataOut[95:64]), DW'(32'h0000_000C));

    // 3: Tnew=0 must not wrap; Tnew=7 max
    c = 31'h7FFF_F8FF;
    cycle("tnew0", 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_3008, d, c);
    check_val("tnew0_abs", DW'(CtrlOut[10:8]), DW'(3'd0));
    c = 31'h0000_0700;
    cycle("tnew7", 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 32'h0000_300C, d, c);

    // 4: load A then stall 3 cycles with changing inputs
    c = 31'h1234_5300;
    cycle("loadA", 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 32'h0000_3010, {3{32'hA5A5_A5A5}}, c);
    for (int i = 0; i < 3; i++)
      cycle("stall", 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, {$urandom, $urandom, $urandom}, CL'($urandom));
`ifdef PIPE_REG_STATS_EN
    check_val("stall_abs", DW'(stall_cnt_s), DW'(16'd3));
`endif

    // 5: flush overrides stall
    cycle("flush", 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_3010, {3{32'hFFFF_FFFF}}, {CL{1'b1}});
    check_val("flush_pc_abs", DW'(PCOut), DW'(32'h0000_3010));
`ifdef PIPE_REG_STATS_EN
    check_val("bubble_abs", DW'(bubble_cnt_s), DW'(16'd1));
`endif

    // load with ValidIn=0 stores inputs as given
    cycle("load_v0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_0BAD, 32'h0000_3020, d, 31'h0000_0200);

    // 6: reset mid-stall
    cycle("loadB", 1'b0, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 32'h0000_3024, d, 31'h5555_5555);
    cycle("stallB", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, {DW{1'b0}}, {CL{1'b0}});
    cycle("rst_stall", 1'b1, 1'b0, 1'b0, 1'b1, 32'hCCCC_CCCC, 32'h0000_4000, d, {CL{1'b1}});

    // random mix
    for (int i = 0; i < 40; i++)
      cycle("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 4) == 0), 1'($urandom), $urandom, $urandom,
            {$urandom, $urandom, $urandom}, CL'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
